// File: rtl/lcd1602_sequencer.sv
// lcd1602_sequencer: HD44780/1602A command/data sequencer.
// Runs the 4-bit power-on initialisation, then forwards host bytes to the
// byte-level LCD bus driver. After each byte it waits out the controller's
// execution time. A watchdog on the driver handshake flags a stuck driver.
module lcd1602_sequencer #(
   parameter int CLK_MHZ        = 20,
   parameter int LINES          = 1,
   parameter int DRV_TIMEOUT_US = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       host_valid,
   input  logic [7:0] host_data,
   input  logic       host_is_data,
   output logic       host_ready,
   input  logic       reinit,
   output logic       drv_en,
   output logic [7:0] drv_data,
   output logic       drv_is_data,
   input  logic       drv_done,
   output logic       init_done,
   output logic       busy,
   output logic       drv_error
);

   typedef enum logic [2:0] {
      PWR_WAIT  = 3'd0,
      INIT_CMD  = 3'd1,
      INIT_WAIT = 3'd2,
      IDLE      = 3'd3,
      XFER      = 3'd4,
      POST_WAIT = 3'd5
   } state_e;

   // Delay counter load values are N-1 so that a wait state lasts exactly N cycles.
   localparam logic [19:0] LD_PWR  = 20'(15000 * CLK_MHZ - 1);
   localparam logic [19:0] LD_4100 = 20'(4100 * CLK_MHZ - 1);
   localparam logic [19:0] LD_1640 = 20'(1640 * CLK_MHZ - 1);
   localparam logic [19:0] LD_100  = 20'(100 * CLK_MHZ - 1);
   localparam logic [19:0] LD_42   = 20'(42 * CLK_MHZ - 1);
   localparam logic [31:0] TO_LAST = 32'(DRV_TIMEOUT_US * CLK_MHZ - 1);
   localparam logic [7:0]  FN_SET  = (LINES != 0) ? 8'h28 : 8'h20;
   localparam logic [2:0]  IDX_LAST = 3'd5;

   // Initialisation ROM: command byte for each step.
   function automatic logic [7:0] rom_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = 8'h33;
         3'd1:    b = 8'h32;
         3'd2:    b = FN_SET;
         3'd3:    b = 8'h0C;
         3'd4:    b = 8'h01;
         3'd5:    b = 8'h06;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Initialisation ROM: execution delay (as a counter load value) for each step.
   function automatic logic [19:0] rom_delay(input logic [2:0] idx);
      logic [19:0] d;
      case (idx)
         3'd0:    d = LD_4100;
         3'd1:    d = LD_100;
         3'd4:    d = LD_1640;
         default: d = LD_42;
      endcase
      return d;
   endfunction

   // Clear-display and return-home are the slow commands; everything else is 42 us.
   function automatic logic [19:0] post_delay(input logic [7:0] b, input logic is_data);
      logic [19:0] d;
      if (!is_data && (b == 8'h01 || b == 8'h02 || b == 8'h03)) begin
         d = LD_1640;
      end else begin
         d = LD_42;
      end
      return d;
   endfunction

   state_e      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        drv_en_q, drv_en_d;
   logic [7:0]  drv_data_q, drv_data_d;
   logic        drv_is_data_q, drv_is_data_d;
   logic        init_done_q, init_done_d;
   logic        host_ready_q, host_ready_d;
   logic        busy_q, busy_d;
   logic        drv_error_q, drv_error_d;

   logic        timeout_s;
   logic        finish_s;
   logic        hs_s;

   // Next-state and output logic for the sequencer FSM.
   always_comb begin
      state_d       = state_q;
      cnt_d         = (cnt_q != 20'd0) ? (cnt_q - 20'd1) : cnt_q;
      idx_d         = idx_q;
      to_cnt_d      = drv_en_q ? (to_cnt_q + 32'd1) : 32'd0;
      drv_en_d      = drv_en_q;
      drv_data_d    = drv_data_q;
      drv_is_data_d = drv_is_data_q;
      init_done_d   = init_done_q;
      drv_error_d   = drv_error_q;

      timeout_s = drv_en_q && !drv_done && (to_cnt_q == TO_LAST);
      finish_s  = drv_en_q && (drv_done || timeout_s);
      hs_s      = host_valid && host_ready_q && !reinit;

      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == 20'd0) begin
               state_d       = INIT_CMD;
               drv_en_d      = 1'b1;
               drv_data_d    = rom_byte(idx_q);
               drv_is_data_d = 1'b0;
            end else begin
               state_d = PWR_WAIT;
            end
         end
         INIT_CMD: begin
            if (finish_s) begin
               drv_en_d    = 1'b0;
               cnt_d       = rom_delay(idx_q);
               state_d     = INIT_WAIT;
               drv_error_d = drv_error_q | timeout_s;
            end else begin
               state_d = INIT_CMD;
            end
         end
         INIT_WAIT: begin
            if (cnt_q == 20'd0) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == IDX_LAST) begin
                  state_d     = IDLE;
                  init_done_d = 1'b1;
               end else begin
                  state_d       = INIT_CMD;
                  drv_en_d      = 1'b1;
                  drv_data_d    = rom_byte(idx_q + 3'd1);
                  drv_is_data_d = 1'b0;
               end
            end else begin
               state_d = INIT_WAIT;
            end
         end
         IDLE: begin
            if (hs_s) begin
               state_d       = XFER;
               drv_en_d      = 1'b1;
               drv_data_d    = host_data;
               drv_is_data_d = host_is_data;
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
            if (finish_s) begin
               drv_en_d    = 1'b0;
               cnt_d       = post_delay(drv_data_q, drv_is_data_q);
               state_d     = POST_WAIT;
               drv_error_d = drv_error_q | timeout_s;
            end else begin
               state_d = XFER;
            end
         end
         POST_WAIT: begin
            if (cnt_q == 20'd0) begin
               state_d = IDLE;
            end else begin
               state_d = POST_WAIT;
            end
         end
         default: begin
            state_d  = PWR_WAIT;
            cnt_d    = LD_PWR;
            idx_d    = 3'd0;
            drv_en_d = 1'b0;
         end
      endcase

      // Reinit overrides everything, including a same-cycle host handshake.
      if (reinit) begin
         state_d     = PWR_WAIT;
         cnt_d       = LD_PWR;
         idx_d       = 3'd0;
         drv_en_d    = 1'b0;
         init_done_d = 1'b0;
      end else begin
         init_done_d = init_done_d;
      end

      // IDLE is only reachable with init complete, so ready tracks the IDLE state.
      host_ready_d = (state_d == IDLE);
      busy_d       = (state_d != IDLE);
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= PWR_WAIT;
         cnt_q         <= LD_PWR;
         idx_q         <= 3'd0;
         to_cnt_q      <= 32'd0;
         drv_en_q      <= 1'b0;
         drv_data_q    <= 8'h00;
         drv_is_data_q <= 1'b0;
         init_done_q   <= 1'b0;
         host_ready_q  <= 1'b0;
         busy_q        <= 1'b1;
         drv_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         to_cnt_q      <= to_cnt_d;
         drv_en_q      <= drv_en_d;
         drv_data_q    <= drv_data_d;
         drv_is_data_q <= drv_is_data_d;
         init_done_q   <= init_done_d;
         host_ready_q  <= host_ready_d;
         busy_q        <= busy_d;
         drv_error_q   <= drv_error_d;
      end
   end

   assign host_ready  = host_ready_q;
   assign drv_en      = drv_en_q;
   assign drv_data    = drv_data_q;
   assign drv_is_data = drv_is_data_q;
   assign init_done   = init_done_q;
   assign busy        = busy_q;
   assign drv_error   = drv_error_q;

endmodule
